// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared FUNC3 encodings and FSM state type
// Purpose: RV32 load/store funct3 constants and the responder state enum.
// Ports: none (package).
package data_memory_responder_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_load_extend.sv
// rtl/data_memory_responder_load_extend.sv - byte/half/word lane select with sign/zero extension
// Purpose: turn a stored 32-bit word into the RV32 load result.
// Ports:
//   i_word     [31:0] stored word
//   i_byte_off [1:0]  byte offset within the word (ADDRESS[1:0])
//   i_func3    [2:0]  load funct3
//   o_data     [31:0] extended load result (0 for unsupported funct3)
module data_memory_responder_load_extend
    import data_memory_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Half lane follows bit 1 only; a misaligned bit 0 is ignored.
    assign w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = 32'h0000_0000;
        case (i_func3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_word;
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - latency-programmable data memory responder for the MA stage
// Purpose: accept one load/store, stall via BUSY for LATENCY+1 cycles, then access
//          a word-organised array with byte/half/word granularity.
// Ports:
//   CLK, RESET_N           clock (rising edge), asynchronous active-low reset
//   MEM_READ, MEM_WRITE    request strobes (read wins when both are high)
//   FUNC3 [2:0]            RV32 load/store funct3
//   ADDRESS [31:0]         byte address (word index = ADDRESS[ADDR_W+1:2])
//   WRITE_DATA [31:0]      store data
//   READ_DATA [31:0]       registered load result, held until the next completed load
//   BUSY                   pipeline stall request
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_count;
    logic [ADDR_W-1:0]  r_word_idx;
    logic [1:0]         r_byte_off;
    logic [2:0]         r_func3;
    logic [31:0]        r_wdata;
    logic               r_is_read;
    logic [31:0]        r_read_data;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_accept;
    logic               w_fire;
    logic [31:0]        w_old_word;
    logic [31:0]        w_merged;
    logic               w_wr_en;
    logic [31:0]        w_load_data;
    logic               w_unused_addr;

    assign w_req         = MEM_READ | MEM_WRITE;
    assign w_accept      = (r_state == ST_IDLE) && w_req;
    // The access happens on the last ACCESS cycle, the same edge that enters DONE.
    assign w_fire        = (r_state == ST_ACCESS) && (r_count == 4'd0);
    assign w_old_word    = r_mem[r_word_idx];
    // High address bits wrap modulo DEPTH and are deliberately dropped.
    assign w_unused_addr = ^ADDRESS[31:ADDR_W+2];

    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Combinational so the stage stalls in the request cycle itself.
                BUSY = w_req;
                if (w_req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                BUSY = 1'b1;
                if (r_count == 4'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Request inputs still belong to the finished instruction.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_count     <= 4'd0;
            r_word_idx  <= '0;
            r_byte_off  <= 2'd0;
            r_func3     <= 3'd0;
            r_wdata     <= 32'h0000_0000;
            r_is_read   <= 1'b0;
            r_read_data <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_word_idx <= ADDRESS[ADDR_W+1:2];
                r_byte_off <= ADDRESS[1:0];
                r_func3    <= FUNC3;
                r_wdata    <= WRITE_DATA;
                r_is_read  <= MEM_READ;
                r_count    <= CNT_INIT;
            end else if ((r_state == ST_ACCESS) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_fire && r_is_read) begin
                r_read_data <= w_load_data;
            end
        end
    end

    // Read-modify-write merge of the store lanes into the current word.
    always_comb begin
        w_merged = w_old_word;
        w_wr_en  = 1'b0;
        case (r_func3)
            F3_SB: begin
                w_wr_en = 1'b1;
                case (r_byte_off)
                    2'd0: w_merged[7:0]   = r_wdata[7:0];
                    2'd1: w_merged[15:8]  = r_wdata[7:0];
                    2'd2: w_merged[23:16] = r_wdata[7:0];
                    2'd3: w_merged[31:24] = r_wdata[7:0];
                    default: w_merged = w_old_word;
                endcase
            end
            F3_SH: begin
                w_wr_en = 1'b1;
                if (r_byte_off[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            F3_SW: begin
                w_wr_en  = 1'b1;
                w_merged = r_wdata;
            end
            default: begin
                w_wr_en  = 1'b0;
                w_merged = w_old_word;
            end
        endcase
    end

    // Storage is not reset; an asynchronous reset drops r_state to IDLE,
    // which removes w_fire and so abandons any pending store.
    always_ff @(posedge CLK) begin
        if (w_fire && !r_is_read && w_wr_en) begin
            r_mem[r_word_idx] <= w_merged;
        end
    end

    data_memory_responder_load_extend u_load_extend (
        .i_word     (w_old_word),
        .i_byte_off (r_byte_off),
        .i_func3    (r_func3),
        .o_data     (w_load_data)
    );

    assign READ_DATA = r_read_data;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the MA stage's load/store requests: accepts one request, holds the pipeline via BUSY for a programmable latency, then performs the access.
- Supports RV32 byte, half and word accesses; loads are sign- or zero-extended.
- Word-organised synchronous storage array.
- Read data is registered and stays stable until the next completed load, so the MA_WB register can capture it.

Parameters:
- ADDR_W, 10, word-index width; DEPTH = 2**ADDR_W words.
- LATENCY, 4, cycles in ACCESS state per request; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MEM_READ  in  1  load request from MA stage.
- MEM_WRITE  in  1  store request from MA stage.
- FUNC3  in  3  access size/sign, RV32 load/store funct3 encoding.
- ADDRESS  in  32  byte address.
- WRITE_DATA  in  32  store data; uses the low byte/half for SB/SH.
- READ_DATA  out  32  registered, extended load result.
- BUSY  out  1  stall request to the pipeline.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state=IDLE, counter=0, READ_DATA=0, BUSY=0, latched request cleared.
  - Storage contents are not cleared.
  - Reset mid-ACCESS abandons the request: no write occurs and READ_DATA stays 0.
- Request detection: REQ = MEM_READ | MEM_WRITE.
  - If both are high, the request is a read and the write is suppressed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If REQ: latch ADDRESS, FUNC3, WRITE_DATA and read/write; set counter=LATENCY-1; go to ACCESS.
  - BUSY = REQ, combinational, so the stage stalls in the same cycle.
- ACCESS:
  - BUSY=1.
  - When counter==0: perform the access, go to DONE. Otherwise decrement the counter.
  - Request inputs are ignored; the latched copy is used.
- DONE:
  - BUSY=0 for exactly one cycle, and the pipeline advances at this edge.
  - REQ is ignored (it is still the old instruction).
  - Next state is IDLE.
- Timing: total BUSY-high time per request = LATENCY+1 cycles (1 IDLE cycle + LATENCY ACCESS cycles). No back-to-back acceptance; minimum request spacing is LATENCY+2 cycles.
- Address mapping:
  - word index = ADDRESS[ADDR_W+1:2].
  - Upper address bits are ignored, so accesses wrap modulo DEPTH words.
- Store, by FUNC3:
  - 000 SB: write byte lane ADDRESS[1:0] with WRITE_DATA[7:0].
  - 001 SH: write half ADDRESS[1] with WRITE_DATA[15:0]; ADDRESS[0] is ignored.
  - 010 SW: write the full word; ADDRESS[1:0] is ignored.
  - Any other FUNC3: no write.
- Load, by FUNC3; the selected byte/half lane uses the same lane selection as stores:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the half.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the half.
  - Other FUNC3: READ_DATA=0.
- READ_DATA:
  - Updates only on the ACCESS→DONE edge of a read.
  - Otherwise holds, including across stores.
- A store followed by a load to the same word returns the updated data (the write commits before the next request is accepted).

Decomposition:
- Shared package holds:
  - FUNC3 constants: LB/LH/LW/LBU/LHU, SB/SH/SW.
  - State enum: IDLE/ACCESS/DONE.
- One natural combinational sub-module, load_extend: inputs word, byte offset and FUNC3; output the extended 32-bit value.
- The byte-enable/merge for stores stays inline.

Test Plan:
- Reset then SW addr 0x10 data 0xDEADBEEF, LATENCY=4 → BUSY high 5 cycles, low 1 cycle (DONE). A following LW 0x10 → READ_DATA=0xDEADBEEF after 5 BUSY cycles.
- Byte/half loads on word 0xDEADBEEF at 0x10:
  - LB 0x13 → 0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD.
  - LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x12345677 onto 0xDEADBEEF → LW 0x10 returns 0xDEAD77EF. SH 0x12 data 0x0000CAFE → next LW returns 0xCAFE77EF.
- Reset during ACCESS of SW 0x20 data 0x1 (old value 0x0) → BUSY=0 and READ_DATA=0 immediately; a later LW 0x20 returns 0x00000000.
- MEM_READ and MEM_WRITE both high at 0x10 → read performed, word unchanged. Request held high through DONE → no second access (BUSY stays low in DONE, returns to IDLE). Address 0x10+4*DEPTH aliases 0x10.
- LATENCY=1 → BUSY high exactly 2 cycles. Illegal FUNC3 011 load → READ_DATA=0. FUNC3 011 store → memory unchanged.
